// File: rtl/pt100_adc_uart_tx.sv
// PT100 ADC link transmitter: one 10-bit sample is sent as two tagged 8N2 UART frames.
// Optional inter-frame idle gap enabled by defining PT100_TX_GAP_EN.
module pt100_adc_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int GAP_BITS     = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] adc_i,
  input  logic       adc_valid_i,
  output logic       adc_ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  // The bit counter is shared by data bits, stop bits and gap bits.
  localparam int BW = (GAP_BITS > 8) ? $clog2(GAP_BITS) : 3;

`ifdef PT100_TX_GAP_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            byte_q, byte_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      hold_q, hold_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            baud_end_s;

  assign baud_end_s  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign adc_ready_o = (state_q == ST_IDLE) & rst_ni;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  // Next-state, line level and counter updates; tx_d is the level of the following cycle.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (baud_end_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = {CW{1'b0}};
        tx_d  = 1'b1;
        if (adc_valid_i) begin
          state_d = ST_START;
          shift_d = {1'b1, adc_i[9:3]};
          hold_d  = adc_i[2:0];
          bit_d   = {BW{1'b0}};
          byte_d  = 1'b0;
          tx_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (baud_end_s) begin
          state_d = ST_DATA;
          bit_d   = {BW{1'b0}};
          tx_d    = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end

      ST_DATA: begin
        if (baud_end_s) begin
          if (bit_q == BW'(7)) begin
            state_d = ST_STOP;
            bit_d   = {BW{1'b0}};
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_q[1];
          end
        end else begin
          tx_d = shift_q[0];
        end
      end

      ST_STOP: begin
        if (baud_end_s) begin
          if (bit_q == {BW{1'b0}}) begin
            bit_d = BW'(1);
            tx_d  = 1'b1;
          end else if (!byte_q) begin
            // Second frame carries the low bits with the tag bit cleared.
            shift_d = {5'b00000, hold_q};
            byte_d  = 1'b1;
            bit_d   = {BW{1'b0}};
`ifdef PT100_TX_GAP_EN
            if (GAP_BITS > 0) begin
              state_d = ST_GAP;
              tx_d    = 1'b1;
            end else begin
              state_d = ST_START;
              tx_d    = 1'b0;
            end
`else
            state_d = ST_START;
            tx_d    = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end else begin
          tx_d = 1'b1;
        end
      end

`ifdef PT100_TX_GAP_EN
      ST_GAP: begin
        if (baud_end_s) begin
          if (bit_q == BW'(GAP_BITS - 1)) begin
            state_d = ST_START;
            bit_d   = {BW{1'b0}};
            tx_d    = 1'b0;
          end else begin
            bit_d = bit_q + BW'(1);
            tx_d  = 1'b1;
          end
        end else begin
          tx_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
        bit_d   = {BW{1'b0}};
        byte_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      bit_q   <= {BW{1'b0}};
      byte_q  <= 1'b0;
      shift_q <= 8'h00;
      hold_q  <= 3'b000;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pt100_adc_uart_tx.sv
// Bench for pt100_adc_uart_tx: per-cycle line/handshake model plus bit-centre decoding
// against hand-computed bytes. Honours PT100_TX_GAP_EN when defined.
module tb_pt100_adc_uart_tx;

  localparam int CPB      = 16;
  localparam int GAP_BITS = 2;
`ifdef PT100_TX_GAP_EN
  localparam int GAP_CYC  = GAP_BITS * CPB;
`else
  localparam int GAP_CYC  = 0;
`endif
  localparam int XFER_CYC = 22 * CPB + GAP_CYC;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [9:0] adc = 10'h000;
  logic       adc_valid = 1'b0;
  logic       adc_ready, tx, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  pt100_adc_uart_tx #(
    .CLK_FREQ    (50000000),
    .BAUD        (9600),
    .CLKS_PER_BIT(CPB),
    .GAP_BITS    (GAP_BITS)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .adc_i      (adc),
    .adc_valid_i(adc_valid),
    .adc_ready_o(adc_ready),
    .tx_o       (tx),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: on accept, the full expected line waveform is queued one entry per cycle.
  bit   line_q[$];
  bit   m_active = 1'b0;
  bit   m_done   = 1'b0;
  bit   m_armed  = 1'b0;

  task automatic push_frame(input logic [7:0] b);
    for (int c = 0; c < CPB; c++) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB; c++) line_q.push_back(b[i]);
    for (int c = 0; c < 2 * CPB; c++) line_q.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_ni) begin
      line_q.delete();
      m_active = 1'b0;
      m_armed  = 1'b1;
    end else if (m_active) begin
      void'(line_q.pop_front());
      if (line_q.size() == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (adc_valid && m_armed) begin
      push_frame({1'b1, adc[9:3]});
      for (int c = 0; c < GAP_CYC; c++) line_q.push_back(1'b1);
      push_frame({5'b00000, adc[2:0]});
      m_active = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      chk("tx_cycle",    {31'd0, tx},        {31'd0, (m_active ? line_q[0] : 1'b1)});
      chk("busy_cycle",  {31'd0, busy},      {31'd0, m_active});
      chk("done_cycle",  {31'd0, done},      {31'd0, m_done});
      chk("ready_cycle", {31'd0, adc_ready}, {31'd0, (!m_active && rst_ni)});
    end
  end

  // Called just after the accept edge: decodes both frames at bit centres and times done_o.
  task automatic xfer_check(input string nm, input logic [7:0] e1, input logic [7:0] e2);
    logic [21:0] bits;
    int off;
    bits = '0;
    @(negedge clk);
    off = 0;
    chk({nm, "_first_low"}, {31'd0, tx}, 32'd0);
    repeat (CPB / 2) @(negedge clk);
    off = CPB / 2;
    for (int j = 0; j < 22; j++) begin
      if (j > 0) begin
        repeat (CPB + ((j == 11) ? GAP_CYC : 0)) @(negedge clk);
        off = off + CPB + ((j == 11) ? GAP_CYC : 0);
      end
      bits[j] = tx;
    end
    chk({nm, "_start1"}, {31'd0, bits[0]},     32'd0);
    chk({nm, "_byte1"},  {24'd0, bits[8:1]},   {24'd0, e1});
    chk({nm, "_stop1"},  {30'd0, bits[10:9]},  32'd3);
    chk({nm, "_start2"}, {31'd0, bits[11]},    32'd0);
    chk({nm, "_byte2"},  {24'd0, bits[19:12]}, {24'd0, e2});
    chk({nm, "_stop2"},  {30'd0, bits[21:20]}, 32'd3);
    while (!done && off < XFER_CYC + 32) begin
      @(negedge clk);
      off++;
    end
    chk({nm, "_done_seen"},   {31'd0, done}, 32'd1);
    chk({nm, "_done_offset"}, off,           XFER_CYC);
  endtask

  // Presents one sample for a single accept edge, then scrambles adc_i.
  task automatic accept(input logic [9:0] v);
    @(posedge clk); #1;
    adc = v;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    adc = ~v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    // Reset and idle.
    adc_valid = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_tx",    {31'd0, tx},        32'd1);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_ready", {31'd0, adc_ready}, 32'd0);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, adc_ready}, 32'd1);
    chk("idle_tx",    {31'd0, tx},        32'd1);

    // Basic transfer and boundary values.
    accept(10'h2D5); xfer_check("x2D5", 8'hDA, 8'h05);
    accept(10'h000); xfer_check("x000", 8'h80, 8'h00);
    accept(10'h3FF); xfer_check("x3FF", 8'hFF, 8'h07);

    // Reset during frame-1 data bit 3.
    accept(10'h2D5);
    repeat (71) @(negedge clk);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tx",   {31'd0, tx},   32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    dn = 0;
    repeat (400) begin
      @(negedge clk);
      dn = dn + int'(done);
    end
    chk("midrst_no_done", dn, 32'd0);
    accept(10'h3FF); xfer_check("after_rst", 8'hFF, 8'h07);

    // Held valid with changing data, then back-to-back accept in the done cycle.
    @(posedge clk); #1;
    adc = 10'h155;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc = 10'h0AA;
    xfer_check("b2b_a", 8'hAA, 8'h05);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    adc = 10'h3C3;
    xfer_check("b2b_b", 8'h95, 8'h02);

    // Gap case when enabled; plain transfer otherwise.
    accept(10'h155); xfer_check("x155", 8'hAA, 8'h05);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pt100_adc_uart_tx.md
Name: pt100_adc_uart_tx

Overview:
- Sensor-side transmitter for the PT100 ADC link; the opposite end of the PT100 UART receiver/rebuilder.
- Accepts one 10-bit ADC sample per handshake and serialises it as two UART frames at BAUD bps: 8N2, LSB first.
  - Frame 1 (MSB byte) = {1'b1, adc[9:3]}.
  - Frame 2 (LSB byte) = {1'b0, 4'b0000, adc[2:0]}.
- Bit 7 of each byte tags it as the MSB or LSB part, as the far-end rebuilder requires.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208), clock cycles per bit. Must be >= 2. Overridable for simulation.
- GAP_BITS, 2, idle bit-times inserted between frame 1 and frame 2. Used only with the optional feature.

Ports:
- clk_i, in, 1, system clock @50 MHz.
- rst_ni, in, 1, synchronous active-low reset.
- adc_i, in, 10, sample to send; captured on accept.
- adc_valid_i, in, 1, sample request.
- adc_ready_o, out, 1, high when idle and able to accept.
- tx_o, out, 1, UART line; idle high.
- busy_o, out, 1, high from the cycle after accept until the transfer completes.
- done_o, out, 1, one-cycle pulse when the last stop bit of frame 2 ends.

Behaviour:
- All state is registered on the clk_i rising edge. tx_o is driven from a flop (glitch-free).
- Reset (rst_ni low at an edge):
  - FSM goes to IDLE; tx_o=1, busy_o=0, done_o=0; bit/byte counters = 0.
  - adc_ready_o=0 while rst_ni is low. Requests during reset are ignored.
- Reset mid-transfer: line returns high at the next edge, the transfer is abandoned, and done_o is not pulsed.
- adc_ready_o = (state==IDLE) & rst_ni.
- Accept: adc_valid_i & adc_ready_o at edge k.
  - At edge k: adc_i is latched into shift byte {1, adc[9:3]}, adc[2:0] is latched into a holding register, and the FSM goes to START.
  - tx_o goes 0 from edge k (visible in cycle k+1).
- FSM states: IDLE, START, DATA, STOP, GAP (GAP only with the optional feature).
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_o = shift[0], shifted right every CLKS_PER_BIT cycles; bit counter 0..7. After bit 7, go to STOP.
  - STOP: tx_o=1 for 2*CLKS_PER_BIT cycles. Then:
    - byte index 0: load {0,0000,adc[2:0]} and go to START (or to GAP when enabled).
    - byte index 1: go to IDLE with done_o=1 for exactly one cycle.
- Timing:
  - The baud counter runs 0..CLKS_PER_BIT-1, reloads at each bit boundary, and is cleared on accept.
  - Total transfer without gap: 22*CLKS_PER_BIT cycles from the first low cycle of tx_o to done_o.
  - adc_ready_o returns high in the same cycle as done_o.
  - Back-to-back accept is allowed in the done_o cycle: the next start bit follows with zero idle time.
- Input stability: adc_i changes after accept do not affect the transfer in flight. adc_valid_i held high while busy is ignored (no queueing).
- No parity. Both stop bits are always 1.

Optional Feature:
- Macro: PT100_TX_GAP_EN.
- Defined:
  - After the stop bits of frame 1, the FSM enters GAP, holds tx_o=1 for GAP_BITS*CLKS_PER_BIT cycles, then sends frame 2.
  - Transfer length becomes (22+GAP_BITS)*CLKS_PER_BIT cycles.
  - If GAP_BITS=0, GAP lasts zero cycles: behaviour is identical to undefined.
- Undefined: the GAP state and GAP_BITS logic are absent. Frame 2 start bit immediately follows frame 1 stop bit 2.

Test Plan (CLKS_PER_BIT=16 unless stated):
- Reset/idle:
  - rst_ni low 5 cycles -> tx_o=1, busy_o=0, done_o=0, adc_ready_o=0.
  - After release -> adc_ready_o=1 next cycle, tx_o stays 1.
- Basic transfer: accept adc_i=10'h2D5 -> sampled at bit centres, line carries:
  - frame 1: 0, bits of 8'hDA (LSB first: 0,1,0,1,1,0,1,1), 1,1;
  - frame 2: 0, bits of 8'h05, 1,1.
  - done_o pulses 352 cycles after the first low.
- Boundary values:
  - adc_i=10'h000 -> bytes 8'h80, 8'h00.
  - adc_i=10'h3FF -> bytes 8'hFF, 8'h07.
  - Loopback through the PT100 UART receiver/rebuilder (CLKS_PER_BIT matched to its 8x clock) -> its output equals each sent value.
- Input change/back-to-back:
  - Change adc_i and hold adc_valid_i high during transfer -> in-flight bytes unchanged, no second accept before done_o.
  - Accept in the done_o cycle -> next start bit with no idle gap.
- Reset mid-frame: drop rst_ni during DATA bit 3 of frame 1 -> tx_o=1 next cycle, no done_o. A new accept afterwards sends a full correct transfer.
- PT100_TX_GAP_EN, GAP_BITS=2: adc_i=10'h155 -> tx_o high for exactly 32 cycles between frame-1 stop bit 2 and frame-2 start. done_o at 384 cycles.
